// File: rtl/hdmi_timing_pkg.sv
// Shared constants, state encoding and RGB field helpers for the HDMI timing path.
// Defaults describe a 720p60 raster.
package hdmi_timing_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  localparam logic [23:0] DEF_UNDERFLOW_RGB = 24'hFF00FF;

  localparam int RGB_CH_W  = 8;
  localparam int RGB_R_LSB = 16;
  localparam int RGB_G_LSB = 8;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  function automatic rgb_t rgb_unpack(input logic [23:0] word);
    rgb_t px;
    px.r = word[RGB_R_LSB +: RGB_CH_W];
    px.g = word[RGB_G_LSB +: RGB_CH_W];
    px.b = word[RGB_B_LSB +: RGB_CH_W];
    return px;
  endfunction

endpackage

// File: rtl/hdmi_raster_cnt.sv
// Horizontal/vertical raster counter pair with run and synchronous clear.
// The vertical counter steps when the horizontal counter wraps.
module hdmi_raster_cnt #(
  parameter int H_TOTAL = 1650,
  parameter int V_TOTAL = 750,
  parameter int HW      = $clog2(H_TOTAL),
  parameter int VW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_clr,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_end_of_line,
  output logic          o_end_of_frame
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_eol;
  logic          w_eof;

  assign w_eol = (r_h_cnt == H_LAST);
  assign w_eof = w_eol && (r_v_cnt == V_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_clr) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_run) begin
      if (w_eol) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_eof ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  assign o_h_cnt        = r_h_cnt;
  assign o_v_cnt        = r_v_cnt;
  assign o_end_of_line  = w_eol;
  assign o_end_of_frame = w_eof;

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing generator and pixel scheduler feeding the HDMI encoders.
// Stage 0 is combinational from the raster counters; syncs, de and RGB are registered once.
module hdmi_timing_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter int          H_ACTIVE      = DEF_H_ACTIVE,
  parameter int          H_FP          = DEF_H_FP,
  parameter int          H_SYNC        = DEF_H_SYNC,
  parameter int          H_BP          = DEF_H_BP,
  parameter int          V_ACTIVE      = DEF_V_ACTIVE,
  parameter int          V_FP          = DEF_V_FP,
  parameter int          V_SYNC        = DEF_V_SYNC,
  parameter int          V_BP          = DEF_V_BP,
  parameter logic        SYNC_POL      = 1'b1,
  parameter logic [23:0] UNDERFLOW_RGB = DEF_UNDERFLOW_RGB
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        line_start,
  output logic [7:0]  rgb_red,
  output logic [7:0]  rgb_green,
  output logic [7:0]  rgb_blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        underflow,
  input  logic        clr_underflow,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_e        r_state;
  state_e        w_state_next;
  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_eol;
  logic          w_eof;
  logic          w_running;
  logic          w_active;
  logic          w_hs_region;
  logic          w_vs_region;
  logic          w_ready;
  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_underflow;
  logic [23:0]   r_rgb;
  rgb_t          w_rgb;

  assign w_running = (r_state != ST_IDLE);

  // Counters sit at (0,0) while idle so a new run always begins on a frame boundary.
  hdmi_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_raster (
    .i_clk          (sys_clk),
    .i_rst          (sys_rst),
    .i_run          (w_running),
    .i_clr          (!w_running),
    .o_h_cnt        (w_h_cnt),
    .o_v_cnt        (w_v_cnt),
    .o_end_of_line  (w_eol),
    .o_end_of_frame (w_eof)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_next = ST_RUN;
      ST_RUN:   if (!enable) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)              w_state_next = ST_RUN;
        else if (w_eol && w_eof) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign w_active    = (w_h_cnt < H_ACT_END) && (w_v_cnt < V_ACT_END);
  assign w_hs_region = (w_h_cnt >= HS_BEG) && (w_h_cnt < HS_END);
  assign w_vs_region = (w_v_cnt >= VS_BEG) && (w_v_cnt < VS_END);

  // Valid/ready: a pixel transfers on any cycle where pix_ready and pix_valid are both high;
  // pix_ready never looks at pix_valid, and a missing pixel is replaced rather than retried.
  assign w_ready     = w_active && w_running;
  assign pix_ready   = w_ready;
  assign frame_start = w_ready && (w_h_cnt == '0) && (w_v_cnt == '0);
  assign line_start  = w_ready && (w_h_cnt == '0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_de        <= 1'b0;
      r_hsync     <= ~SYNC_POL;
      r_vsync     <= ~SYNC_POL;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_de    <= w_ready;
      r_hsync <= (w_running && w_hs_region) ? SYNC_POL : ~SYNC_POL;
      r_vsync <= (w_running && w_vs_region) ? SYNC_POL : ~SYNC_POL;
      if (w_ready) r_rgb <= pix_valid ? pix_data : UNDERFLOW_RGB;
      else         r_rgb <= '0;
      if (w_ready && !pix_valid) r_underflow <= 1'b1;
      else if (clr_underflow)    r_underflow <= 1'b0;
    end
  end

  assign w_rgb     = rgb_unpack(r_rgb);
  assign rgb_red   = w_rgb.r;
  assign rgb_green = w_rgb.g;
  assign rgb_blue  = w_rgb.b;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;
  assign underflow = r_underflow;
  assign busy      = w_running;
  assign dbg_state = r_state;

endmodule

// File: doc/hdmi_timing_ctrl.md
Name: hdmi_timing_ctrl

Overview:
Video timing controller and pixel scheduler that drives the HDMI transmit datapath (the 8b/10b encoders and the serialisers).
- Generates hsync/vsync/de from parameterised raster counters.
- Pulls pixels from an upstream source (frame buffer or CV pipeline) with a valid/ready handshake.
- Presents registered RGB to the encoders, substituting a fixed colour on source underflow.
- Starts cleanly on a frame boundary and stops only at the end of a frame.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
- UNDERFLOW_RGB, 24'hFF00FF, colour output when the source is not valid during active video ({R,G,B})

Ports:
- sys_clk  in  1  pixel clock (clk_1x domain)
- sys_rst  in  1  asynchronous reset, active-high
- enable  in  1  run request; sampled every cycle
- pix_valid  in  1  upstream pixel valid
- pix_data  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- pix_ready  out  1  pixel consumed this cycle when pix_valid is also high
- frame_start  out  1  one-cycle pulse with first pix_ready of each frame
- line_start  out  1  one-cycle pulse with first pix_ready of each active line
- rgb_red  out  8  to encoder
- rgb_green  out  8  to encoder
- rgb_blue  out  8  to encoder
- hsync  out  1  to encoder c0
- vsync  out  1  to encoder c1
- de  out  1  to encoder de
- underflow  out  1  sticky; set on any active cycle with pix_valid=0
- clr_underflow  in  1  clears underflow; set has priority when both occur in the same cycle
- busy  out  1  high in RUN or DRAIN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. h_cnt counts 0..H_TOTAL-1; v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1. Counter width is clog2 of the respective total.
- Reset (async, immediate, also mid-frame):
  - state=IDLE, counters=0.
  - hsync=vsync=~SYNC_POL, de=0, rgb=0.
  - pix_ready, frame_start, line_start, underflow, busy = 0.
- FSM:
  - IDLE: counters held at 0. enable=1 -> RUN on the next cycle, with counters starting at (0,0).
  - RUN: counters advance every cycle. enable=0 -> DRAIN.
  - DRAIN: counters keep advancing. enable=1 -> RUN (no gap). At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 -> IDLE.
  - A frame is never truncated except by reset.
- Regions, computed combinationally from the counters (stage 0):
  - active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hs_region = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_region = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vsync changes on line boundaries only.
- Handshake (stage 0):
  - pix_ready = active and state!=IDLE. Combinational from the counter registers; no dependency on pix_valid.
  - frame_start = pix_ready and h_cnt=0 and v_cnt=0.
  - line_start = pix_ready and h_cnt=0.
- Output stage: registered, 1 cycle latency after stage 0.
  - de <= pix_ready.
  - hsync <= hs_region ? SYNC_POL : ~SYNC_POL; vsync likewise.
  - rgb <= pix_ready ? (pix_valid ? pix_data : UNDERFLOW_RGB) : 0.
  - Syncs are forced inactive in IDLE.
- Underflow: pix_ready=1 and pix_valid=0 sets underflow on the next cycle. It stays set until clr_underflow, and the pixel slot is not retried (raster never stalls).
- pix_valid outside pix_ready is ignored; no data is consumed.

Decomposition:
- Package hdmi_timing_pkg:
  - 720p60 default constants (H_/V_ values above).
  - FSM state encoding (IDLE, RUN, DRAIN).
  - RGB pack/unpack field positions.
- Sub-module hdmi_raster_cnt:
  - Parameterised h/v counter pair with run and clear inputs.
  - Outputs h_cnt, v_cnt, end_of_line and end_of_frame.
  - Reused by later overlay/ROI blocks.

Test Plan (small raster: H 4/1/2/1 -> H_TOTAL 8; V 3/1/1/1 -> V_TOTAL 6; 48-cycle frame; SYNC_POL=1):
- Reset then enable=1, pix_valid=1, pix_data incrementing from 0x000001 -> frame_start on the 2nd cycle after reset release; de high 4 cycles per line for lines 0-2 (12 pixels/frame); rgb matches pixels 1..12 one cycle after pix_ready.
- Sync timing -> hsync high exactly at cycles h=5,6 of each line plus 1 latency; vsync high for all 8 cycles of line 4 (+1); de=0 throughout lines 3-5.
- pix_valid=0 on the 3rd active pixel of line 1 -> that output is FF00FF; underflow=1 from the next cycle; next pixel is the next source word; clr_underflow -> underflow=0.
- enable dropped at h=2,v=1 -> busy stays 1, raster completes to (7,5), then IDLE: de=0, syncs=0, pix_ready=0. Re-enable during DRAIN -> next frame follows with zero idle cycles.
- sys_rst asserted mid active line -> all outputs at reset values in the same cycle (async); after release with enable=1, the frame restarts at (0,0) with frame_start.
- pix_valid=1 held during blanking -> pix_ready=0 and no data consumed; the first active pixel after blanking equals the next unconsumed source word.
